// File: rtl/regfile_wb_queue.sv
// Write-side front end of the register file: queues writeback requests,
// drains one per cycle onto the regfile write port, and lets decode look up
// values that are still pending in the queue or sitting on the write port.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data,
    input  logic                     flush,
    input  logic                     wb_stall,
    output logic                     wb_we,
    output logic [AW-1:0]            wb_waddr,
    output logic [DW-1:0]            wb_wdata,
    input  logic [AW-1:0]            fwd_addr1,
    output logic                     fwd_hit1,
    output logic [DW-1:0]            fwd_data1,
    input  logic [AW-1:0]            fwd_addr2,
    output logic                     fwd_hit2,
    output logic [DW-1:0]            fwd_data2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic push;
    logic pop;

    // Writes to r0 still complete the handshake but are never queued.
    assign in_ready = rst_n & (count != CW'(DEPTH)) & ~flush;
    assign push     = in_valid & in_ready & (in_addr != '0);
    assign pop      = (count != '0) & ~wb_stall & ~flush;

    // Queue pointers and occupancy; flush wins over push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= in_addr;
            data_mem[wr_ptr] <= in_data;
        end
    end

    // Staged regfile write: head moves onto wb_* on pop, address/data hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we    <= 1'b0;
            wb_waddr <= '0;
            wb_wdata <= '0;
        end else if (flush) begin
            wb_we    <= 1'b0;
        end else if (pop) begin
            wb_we    <= 1'b1;
            wb_waddr <= addr_mem[rd_ptr];
            wb_wdata <= data_mem[rd_ptr];
        end else begin
            wb_we    <= 1'b0;
        end
    end

    logic [AW-1:0] look_addr [2];
    logic          look_hit  [2];
    logic [DW-1:0] look_data [2];

    assign look_addr[0] = fwd_addr1;
    assign look_addr[1] = fwd_addr2;
    assign fwd_hit1     = look_hit[0];
    assign fwd_data1    = look_data[0];
    assign fwd_hit2     = look_hit[1];
    assign fwd_data2    = look_data[1];

    // Forwarding lookup: staged entry first, then live entries oldest to
    // youngest so the youngest match overwrites; r0 never hits.
    always_comb begin
        logic [PW-1:0] idx;
        idx = '0;
        for (int p = 0; p < 2; p++) begin
            look_hit[p]  = 1'b0;
            look_data[p] = '0;
            if (wb_we && (wb_waddr == look_addr[p])) begin
                look_hit[p]  = 1'b1;
                look_data[p] = wb_wdata;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + PW'(i);
                if ((CW'(i) < count) && (addr_mem[idx] == look_addr[p])) begin
                    look_hit[p]  = 1'b1;
                    look_data[p] = data_mem[idx];
                end
            end
            if (look_addr[p] == '0) begin
                look_hit[p]  = 1'b0;
                look_data[p] = '0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue: inputs change one time unit after a
// rising edge, results are sampled before the next rising edge.
module tb_regfile_wb_queue;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_addr;
   logic [31:0] in_data;
   logic        flush;
   logic        wb_stall;
   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic [4:0]  fwd_addr1;
   logic        fwd_hit1;
   logic [31:0] fwd_data1;
   logic [4:0]  fwd_addr2;
   logic        fwd_hit2;
   logic [31:0] fwd_data2;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   regfile_wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_addr   (in_addr),
      .in_data   (in_data),
      .flush     (flush),
      .wb_stall  (wb_stall),
      .wb_we     (wb_we),
      .wb_waddr  (wb_waddr),
      .wb_wdata  (wb_wdata),
      .fwd_addr1 (fwd_addr1),
      .fwd_hit1  (fwd_hit1),
      .fwd_data1 (fwd_data1),
      .fwd_addr2 (fwd_addr2),
      .fwd_hit2  (fwd_hit2),
      .fwd_data2 (fwd_data2),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [4:0] a, input logic [31:0] d);
      in_valid = 1'b1;
      in_addr  = a;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_addr   = '0;
      in_data   = '0;
      flush     = 1'b0;
      wb_stall  = 1'b0;
      fwd_addr1 = '0;
      fwd_addr2 = '0;

      // reset state
      #2;
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_count", count, 3'd0);
      chk("rst_wb_we", wb_we, 1'b0);
      chk("rst_wb_waddr", wb_waddr, 5'd0);
      chk("rst_wb_wdata", wb_wdata, 32'd0);
      #10;
      rst_n = 1'b1;
      tick();
      chk("post_rst_in_ready", in_ready, 1'b1);

      // 1: single push, minimum latency
      push_one(5'd5, 32'h11111111);
      chk("t1_count_after_push", count, 3'd1);
      chk("t1_we_after_push", wb_we, 1'b0);
      tick();
      chk("t1_we", wb_we, 1'b1);
      chk("t1_waddr", wb_waddr, 5'd5);
      chk("t1_wdata", wb_wdata, 32'h11111111);
      chk("t1_count_staged", count, 3'd0);
      tick();
      chk("t1_we_clear", wb_we, 1'b0);
      chk("t1_waddr_hold", wb_waddr, 5'd5);
      chk("t1_count_end", count, 3'd0);

      // 2: fill under stall, hold 5th, drain in order
      wb_stall = 1'b1;
      for (int i = 1; i <= 4; i++) push_one(5'(i), 32'hA0000000 + 32'(i));
      chk("t2_count_full", count, 3'd4);
      chk("t2_in_ready_full", in_ready, 1'b0);
      in_valid = 1'b1;
      in_addr  = 5'd6;
      in_data  = 32'hA0000006;
      tick();
      chk("t2_count_hold", count, 3'd4);
      chk("t2_we_stalled", wb_we, 1'b0);
      wb_stall = 1'b0;
      tick();
      chk("t2_r1_addr", wb_waddr, 5'd1);
      chk("t2_r1_data", wb_wdata, 32'hA0000001);
      chk("t2_count_3a", count, 3'd3);
      tick();
      in_valid = 1'b0;
      chk("t2_r2_addr", wb_waddr, 5'd2);
      chk("t2_count_3b", count, 3'd3);
      tick();
      chk("t2_r3_addr", wb_waddr, 5'd3);
      chk("t2_count_2", count, 3'd2);
      tick();
      chk("t2_r4_addr", wb_waddr, 5'd4);
      chk("t2_r4_data", wb_wdata, 32'hA0000004);
      tick();
      chk("t2_r6_we", wb_we, 1'b1);
      chk("t2_r6_addr", wb_waddr, 5'd6);
      chk("t2_r6_data", wb_wdata, 32'hA0000006);
      chk("t2_count_0", count, 3'd0);
      tick();
      chk("t2_we_idle", wb_we, 1'b0);

      // 3: forwarding picks youngest duplicate, through staging
      wb_stall = 1'b1;
      push_one(5'd3, 32'h0000000A);
      push_one(5'd3, 32'h0000000B);
      fwd_addr1 = 5'd3;
      #1;
      chk("t3_hit_queued", fwd_hit1, 1'b1);
      chk("t3_data_queued", fwd_data1, 32'h0000000B);
      wb_stall = 1'b0;
      tick();
      chk("t3_staged_a", wb_wdata, 32'h0000000A);
      chk("t3_hit_mixed", fwd_hit1, 1'b1);
      chk("t3_data_mixed", fwd_data1, 32'h0000000B);
      tick();
      chk("t3_count_empty", count, 3'd0);
      chk("t3_hit_staged", fwd_hit1, 1'b1);
      chk("t3_data_staged", fwd_data1, 32'h0000000B);
      tick();
      chk("t3_hit_gone", fwd_hit1, 1'b0);
      chk("t3_data_gone", fwd_data1, 32'h0);
      fwd_addr1 = 5'd0;

      // 4: write to r0 is accepted and discarded
      in_valid = 1'b1;
      in_addr  = 5'd0;
      in_data  = 32'hFFFFFFFF;
      #1;
      chk("t4_in_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("t4_count", count, 3'd0);
      tick();
      chk("t4_we", wb_we, 1'b0);
      fwd_addr2 = 5'd0;
      #1;
      chk("t4_hit2", fwd_hit2, 1'b0);
      chk("t4_data2", fwd_data2, 32'h0);

      // 5: flush discards queue and the same-cycle request
      wb_stall = 1'b1;
      push_one(5'd7, 32'h00000007);
      push_one(5'd8, 32'h00000008);
      push_one(5'd9, 32'h00000009);
      chk("t5_count_3", count, 3'd3);
      fwd_addr1 = 5'd8;
      #1;
      chk("t5_hit_pre", fwd_hit1, 1'b1);
      chk("t5_data_pre", fwd_data1, 32'h00000008);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_addr  = 5'd10;
      in_data  = 32'h0000000C;
      #1;
      chk("t5_in_ready_flush", in_ready, 1'b0);
      tick();
      flush     = 1'b0;
      in_valid  = 1'b0;
      fwd_addr2 = 5'd10;
      #1;
      chk("t5_count_flushed", count, 3'd0);
      chk("t5_we_flushed", wb_we, 1'b0);
      chk("t5_hit1_flushed", fwd_hit1, 1'b0);
      chk("t5_hit2_dropped", fwd_hit2, 1'b0);
      wb_stall = 1'b0;
      tick();
      chk("t5_we_after", wb_we, 1'b0);
      chk("t5_count_after", count, 3'd0);
      fwd_addr1 = 5'd0;
      fwd_addr2 = 5'd0;

      // 6: async reset mid-operation
      wb_stall = 1'b1;
      push_one(5'd11, 32'h0000000B);
      push_one(5'd12, 32'h0000000C);
      push_one(5'd13, 32'h0000000D);
      wb_stall = 1'b0;
      tick();
      chk("t6_pre_count", count, 3'd2);
      chk("t6_pre_we", wb_we, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_we_reset", wb_we, 1'b0);
      chk("t6_count_reset", count, 3'd0);
      chk("t6_in_ready_reset", in_ready, 1'b0);
      chk("t6_waddr_reset", wb_waddr, 5'd0);
      #1;
      rst_n = 1'b1;
      tick();
      chk("t6_count_after", count, 3'd0);
      chk("t6_we_after", wb_we, 1'b0);
      chk("t6_in_ready_after", in_ready, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
